deser_fifo_param: RTL

- Parametrised serial-to-parallel deserializer: assembles WIDTH-bit words from a 1-bit stream qualified by write_in.
- Queues completed words in a DEPTH-entry output FIFO, so reception continues while earlier words wait for ack_in.
- Sits between the bit-serial link front end and the word-level consumer/queue; successor of the fixed 8-bit, single-word deserializer.

---
 rtl/deser_pkg.sv | 16 +
 rtl/deser_word_fifo.sv | 66 ++++++
 rtl/deser_fifo_param.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/deser_pkg.sv
// Shared types and helpers for the serial-to-parallel deserializer.
// The PARITY state is only reachable when DESER_PARITY_EN is defined.
package deser_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RECEIVING = 2'd1,
    PARITY    = 2'd2
  } state_t;

  // Bits needed for a counter that must be able to represent 0..width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/deser_word_fifo.sv
// Word FIFO that holds completed words until the consumer acknowledges them.
// Pointers wrap modulo DEPTH. A push while full is accepted only when a pop
// happens on the same edge. clear empties the queue and overrides push/pop.
// head reads as zero whenever the queue is empty.
module deser_word_fifo #(
  parameter int DW    = 9,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic [DW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == OCC_W'(DEPTH));
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && (!full || do_pop) && !clear;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage array: written only on an accepted push, never reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; clear and reset both empty the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wrap_inc(wr_ptr);
      if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/deser_fifo_param.sv
// Parametrised serial-to-parallel deserializer with a DEPTH-entry output FIFO.
// Optional macro DESER_PARITY_EN: each word is followed by one even-parity
// bit, and a per-entry error flag travels through the FIFO to parity_err.
module deser_fifo_param
  import deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic             clock_100,
  input  logic             reset_n,
  input  logic             data_in,
  input  logic             write_in,
  input  logic             ack_in,
  input  logic             clear_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_ready,
  output logic             status_out,
  output logic             full,
  output logic             overflow,
  output logic             parity_err
);

  localparam int CNT_W = cnt_width(WIDTH);
`ifdef DESER_PARITY_EN
  localparam int FW = WIDTH + 1;
`else
  localparam int FW = WIDTH;
`endif

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic             last_data_bit;
  logic             word_done;
  logic [FW-1:0]    push_word;
  logic [FW-1:0]    head;
  logic             push_req;
  logic             pop_req;
  logic             fifo_full;
  logic             fifo_empty;

  // Shift direction decides which end of the word the first bit lands in.
  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign shift_next = {shift_reg[WIDTH-2:0], data_in};
    end else begin : g_lsb
      assign shift_next = {data_in, shift_reg[WIDTH-1:1]};
    end
  endgenerate

  assign last_data_bit = (state == RECEIVING) && (bit_cnt == CNT_W'(WIDTH - 1));

`ifdef DESER_PARITY_EN
  // The word is already in shift_reg; the parity bit completes the entry.
  assign word_done = write_in && (state == PARITY);
  assign push_word = {^shift_reg ^ data_in, shift_reg};
`else
  assign word_done = write_in && last_data_bit;
  assign push_word = shift_next;
`endif

  assign pop_req  = ack_in && !fifo_empty;
  assign push_req = word_done && !clear_in;

  deser_word_fifo #(
    .DW    (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clock_100),
    .rst_n (reset_n),
    .push  (push_req),
    .pop   (pop_req),
    .clear (clear_in),
    .wdata (push_word),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Assembly FSM: collects bits, tolerates write_in gaps, restarts with no dead cycle.
  always_ff @(posedge clock_100 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (clear_in) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (write_in) begin
      case (state)
        IDLE: begin
          shift_reg <= shift_next;
          bit_cnt   <= CNT_W'(1);
          state     <= RECEIVING;
        end
        RECEIVING: begin
          shift_reg <= shift_next;
          if (last_data_bit) begin
            bit_cnt <= '0;
`ifdef DESER_PARITY_EN
            state   <= PARITY;
`else
            state   <= IDLE;
`endif
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: begin
          bit_cnt <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Sticky drop flag: a finished word found the FIFO full with no pop to free a slot.
  always_ff @(posedge clock_100 or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (clear_in) begin
      overflow <= 1'b0;
    end else if (word_done && fifo_full && !pop_req) begin
      overflow <= 1'b1;
    end
  end

  assign status_out = (state != IDLE);
  assign data_out   = head[WIDTH-1:0];
  assign data_ready = !fifo_empty;
  assign full       = fifo_full;
`ifdef DESER_PARITY_EN
  assign parity_err = head[WIDTH];
`else
  assign parity_err = 1'b0;
`endif

endmodule
